// File: rtl/uart_wb_master.sv
// UART byte-stream command decoder acting as a single-word Wishbone classic master.
// Optional build macro UART_WB_TIMEOUT_EN adds an ack timeout that answers 'E'.
module uart_wb_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        rx_error,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    WB   = 3'd3,
    RESP = 3'd4,
    GAP  = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_r;
  logic [1:0]  idx_r;
  logic        write_r;
  logic [31:0] adr_sh_r;
  logic [31:0] dat_sh_r;
  logic [31:0] resp_buf_r;
  logic [2:0]  resp_cnt_r;
  logic        seen_busy_r;
  logic        cyc_r;

  logic        take_s;
  logic        err_s;
  logic        timeout_s;
  logic        done_s;
  logic [31:0] resp_word_s;
  logic [2:0]  resp_total_s;

  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

  // The cycle carrying rx_ack never samples, so a stale rx_avail is ignored.
  assign take_s   = rx_avail & ~rx_ack;
  assign err_s    = rx_error & ~rx_ack;
  assign done_s   = wb_ack_i | timeout_s;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;

`ifdef UART_WB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_r;

  // Counts WB cycles without ack; held at zero outside WB so it is clear on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= 16'd0;
    end else if (state_r != WB) begin
      to_cnt_r <= 16'd0;
    end else if (!wb_ack_i) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end
  end

  // Limit reached in a cycle with no ack; an ack in that same cycle wins.
  always_comb begin
    if (state_r == WB && !wb_ack_i && to_cnt_r == TO_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Response content chosen at the end of the bus cycle, first byte in the top lane.
  always_comb begin
    resp_word_s  = wb_dat_i;
    resp_total_s = 3'd4;
    if (timeout_s) begin
      resp_word_s  = {RSP_ERR, 24'h000000};
      resp_total_s = 3'd1;
    end else if (write_r) begin
      resp_word_s  = {RSP_OK, 24'h000000};
      resp_total_s = 3'd1;
    end else begin
      resp_word_s  = wb_dat_i;
      resp_total_s = 3'd4;
    end
  end

  // Frame parser, bus master and response sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      write_r     <= 1'b0;
      adr_sh_r    <= 32'h0;
      dat_sh_r    <= 32'h0;
      resp_buf_r  <= 32'h0;
      resp_cnt_r  <= 3'd0;
      seen_busy_r <= 1'b0;
      cyc_r       <= 1'b0;
      rx_ack      <= 1'b0;
      tx_data     <= 8'h00;
      tx_wr       <= 1'b0;
      wb_adr_o    <= 32'h0;
      wb_dat_o    <= 32'h0;
      wb_sel_o    <= 4'h0;
      wb_we_o     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_ack <= 1'b0;
      tx_wr  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (err_s) begin
            rx_ack <= 1'b1;
          end else if (take_s) begin
            rx_ack <= 1'b1;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              write_r <= (rx_data == CMD_WR);
              idx_r   <= 2'd0;
              state_r <= ADDR;
              busy    <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (err_s) begin
            rx_ack  <= 1'b1;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (take_s) begin
            rx_ack   <= 1'b1;
            adr_sh_r <= shift_in(adr_sh_r, rx_data);
            idx_r    <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              if (write_r) begin
                state_r <= DATA;
              end else begin
                state_r  <= WB;
                cyc_r    <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= 1'b0;
                wb_adr_o <= shift_in(adr_sh_r, rx_data);
              end
            end
          end
        end
        DATA: begin
          if (err_s) begin
            rx_ack  <= 1'b1;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (take_s) begin
            rx_ack   <= 1'b1;
            dat_sh_r <= shift_in(dat_sh_r, rx_data);
            idx_r    <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              state_r  <= WB;
              cyc_r    <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_we_o  <= 1'b1;
              wb_adr_o <= adr_sh_r;
              wb_dat_o <= shift_in(dat_sh_r, rx_data);
            end
          end
        end
        WB: begin
          if (done_s) begin
            cyc_r    <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            // Send the first byte straight away when the transmitter is free.
            if (!tx_busy) begin
              tx_data     <= resp_word_s[31:24];
              tx_wr       <= 1'b1;
              resp_buf_r  <= {resp_word_s[23:0], 8'h00};
              resp_cnt_r  <= resp_total_s - 3'd1;
              seen_busy_r <= 1'b0;
              state_r     <= GAP;
            end else begin
              resp_buf_r <= resp_word_s;
              resp_cnt_r <= resp_total_s;
              state_r    <= RESP;
            end
          end
        end
        RESP: begin
          if (!tx_busy && !tx_wr) begin
            tx_data     <= resp_buf_r[31:24];
            tx_wr       <= 1'b1;
            resp_buf_r  <= {resp_buf_r[23:0], 8'h00};
            resp_cnt_r  <= resp_cnt_r - 3'd1;
            seen_busy_r <= 1'b0;
            state_r     <= GAP;
          end
        end
        GAP: begin
          if (tx_busy) begin
            seen_busy_r <= 1'b1;
          end else if (seen_busy_r) begin
            seen_busy_r <= 1'b0;
            if (resp_cnt_r == 3'd0) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= RESP;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          cyc_r    <= 1'b0;
          wb_sel_o <= 4'h0;
          wb_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
